tuner_sweep_ctrl: RTL and testbench

TUNER_SWEEP_CTRL -- requirements
Module: tuner_sweep_ctrl

---
 rtl/wdm_pkg.sv | 15 +
 rtl/tuner_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_tuner_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wdm_pkg.sv
// Shared types and width defaults for the WDM tuner blocks.
package wdm_pkg;

    localparam int WDM_DAC_WIDTH = 8;
    localparam int WDM_ADC_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_READ   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } tuner_sweep_state_e;

endpackage

// File: rtl/tuner_sweep_ctrl.sv
// Sweeps the tuning DAC over [lo, hi], reads detected power at each code and
// locks onto the code with the lowest power (earliest code wins on ties).
module tuner_sweep_ctrl
    import wdm_pkg::*;
#(
    parameter int DAC_WIDTH     = WDM_DAC_WIDTH,
    parameter int ADC_WIDTH     = WDM_ADC_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [DAC_WIDTH-1:0] i_code_lo,
    input  logic [DAC_WIDTH-1:0] i_code_hi,
    output logic [DAC_WIDTH-1:0] o_dac_tune,
    output logic                 o_pwr_read_val,
    input  logic                 i_pwr_read_rdy,
    input  logic                 i_pwr_detect_val,
    input  logic [ADC_WIDTH-1:0] i_pwr_detect_data,
    output logic                 o_pwr_detect_rdy,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DAC_WIDTH-1:0] o_lock_code,
    output logic [ADC_WIDTH-1:0] o_min_pwr,
    output tuner_sweep_state_e   o_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1. o_pwr_read_val holds until accepted; o_pwr_detect_rdy is
    // high for the whole WAIT state and data is taken on the first valid.

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    tuner_sweep_state_e   state;
    logic [DAC_WIDTH-1:0] code;
    logic [DAC_WIDTH-1:0] hi_q;
    logic [DAC_WIDTH-1:0] best_q;
    logic [ADC_WIDTH-1:0] min_q;
    logic [7:0]           settle_cnt;

    logic [DAC_WIDTH-1:0] best_nxt;
    logic [ADC_WIDTH-1:0] min_nxt;

    assign o_state = state;

    // Strict less-than keeps the earliest code on equal power.
    always_comb begin
        best_nxt = best_q;
        min_nxt  = min_q;
        if (i_pwr_detect_data < min_q) begin
            best_nxt = code;
            min_nxt  = i_pwr_detect_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            code             <= '0;
            hi_q             <= '0;
            best_q           <= '0;
            min_q            <= '1;
            settle_cnt       <= '0;
            o_dac_tune       <= '0;
            o_pwr_read_val   <= 1'b0;
            o_pwr_detect_rdy <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_lock_code      <= '0;
            o_min_pwr        <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        code       <= i_code_lo;
                        // A reversed range collapses to the single point lo.
                        hi_q       <= (i_code_hi < i_code_lo) ? i_code_lo : i_code_hi;
                        best_q     <= i_code_lo;
                        min_q      <= '1;
                        settle_cnt <= '0;
                        o_dac_tune <= i_code_lo;
                        o_busy     <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt     <= '0;
                        o_pwr_read_val <= 1'b1;
                        state          <= ST_READ;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_READ: begin
                    if (i_pwr_read_rdy) begin
                        o_pwr_read_val   <= 1'b0;
                        o_pwr_detect_rdy <= 1'b1;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_pwr_detect_val) begin
                        min_q            <= min_nxt;
                        best_q           <= best_nxt;
                        o_pwr_detect_rdy <= 1'b0;
                        // Terminating on code==hi before incrementing means
                        // the all-ones code never wraps.
                        if (code == hi_q) begin
                            o_done      <= 1'b1;
                            o_lock_code <= best_nxt;
                            o_min_pwr   <= min_nxt;
                            o_dac_tune  <= best_nxt;
                            state       <= ST_DONE;
                        end else begin
                            code       <= code + 1'b1;
                            o_dac_tune <= code + 1'b1;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// Directed bench for tuner_sweep_ctrl: a detector model answers reads, a
// monitor pops expected {lock, min, dac} words whenever o_done is seen.
module tb_tuner_sweep_ctrl;
    import wdm_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SC = 4;
    localparam int PT = SC + 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_code_lo = '0;
    logic [DW-1:0] i_code_hi = '0;
    logic [DW-1:0] o_dac_tune;
    logic          o_pwr_read_val;
    logic          i_pwr_read_rdy = 1'b1;
    logic          i_pwr_detect_val = 1'b0;
    logic [AW-1:0] i_pwr_detect_data = '0;
    logic          o_pwr_detect_rdy;
    logic          o_busy;
    logic          o_done;
    logic [DW-1:0] o_lock_code;
    logic [AW-1:0] o_min_pwr;
    tuner_sweep_state_e o_state;

    tuner_sweep_ctrl #(.DAC_WIDTH(DW), .ADC_WIDTH(AW), .SETTLE_CYCLES(SC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_code_lo(i_code_lo), .i_code_hi(i_code_hi), .o_dac_tune(o_dac_tune),
        .o_pwr_read_val(o_pwr_read_val), .i_pwr_read_rdy(i_pwr_read_rdy),
        .i_pwr_detect_val(i_pwr_detect_val), .i_pwr_detect_data(i_pwr_detect_data),
        .o_pwr_detect_rdy(o_pwr_detect_rdy), .o_busy(o_busy), .o_done(o_done),
        .o_lock_code(o_lock_code), .o_min_pwr(o_min_pwr), .o_state(o_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- counters / scoreboard ----------------
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int xfers = 0;
    logic [DW+AW+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- detector model ----------------
    int  mode = 0;       // 0: |code-5|*10, 1: flat 0x40
    bit  junk = 1'b0;    // drive spurious valid/zero data outside WAIT
    int  bp_left = 0;    // stall cycles to apply to the next read request

    function automatic logic [AW-1:0] pwr_of(input logic [DW-1:0] c);
        int d;
        if (mode == 1) return 8'h40;
        d = (int'(c) > 5) ? (int'(c) - 5) : (5 - int'(c));
        return AW'(d * 10);
    endfunction

    always @(negedge i_clk) begin
        if (o_pwr_detect_rdy) begin
            i_pwr_detect_val  = 1'b1;
            i_pwr_detect_data = pwr_of(o_dac_tune);
        end else if (junk) begin
            i_pwr_detect_val  = 1'b1;
            i_pwr_detect_data = '0;
        end else begin
            i_pwr_detect_val  = 1'b0;
            i_pwr_detect_data = '0;
        end
        if (bp_left > 0 && (o_pwr_read_val || bp_left < 6)) begin
            check("read_val_held", 32'(o_pwr_read_val), 32'd1);
            i_pwr_read_rdy = 1'b0;
            bp_left--;
        end else begin
            i_pwr_read_rdy = 1'b1;
        end
    end

    always @(posedge i_clk) begin
        if (!i_rst && o_pwr_read_val && i_pwr_read_rdy) xfers++;
    end

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [DW+AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("lock_code", 32'(o_lock_code), 32'(e[DW+AW+DW-1 -: DW]));
                check("min_pwr", 32'(o_min_pwr), 32'(e[AW+DW-1 -: AW]));
                check("dac_tune", 32'(o_dac_tune), 32'(e[DW-1:0]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_sweep(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                             input int m, input logic [DW-1:0] e_lock,
                             input logic [AW-1:0] e_min, input int exp_cyc,
                             input bit poke);
        int cyc;
        mode = m;
        exp_q.push_back({e_lock, e_min, e_lock});
        @(negedge i_clk);
        i_code_lo = lo;
        i_code_hi = hi;
        i_start   = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        cyc = 0;
        while (!o_done && cyc < 2000) begin
            @(posedge i_clk);
            cyc++;
            #1;
            if (cyc == 1) check("busy_in_sweep", 32'(o_busy), 32'd1);
            if (poke && cyc == 10 && !o_done) begin
                i_code_lo = 8'd1;
                i_code_hi = 8'd1;
                i_start   = 1'b1;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check("done_seen", 32'(o_done), 32'd1);
        check("latency", 32'(cyc), 32'(exp_cyc));
        @(posedge i_clk);
        #1;
        check("busy_after", 32'(o_busy), 32'd0);
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("state_idle", 32'(o_state), 32'(ST_IDLE));
        repeat (3) @(posedge i_clk);
        #1 check("dac_hold_idle", 32'(o_dac_tune), 32'(e_lock));
    endtask

    initial begin
        int n;
        int x0;
        bit found;
        // reset
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_dac", 32'(o_dac_tune), 32'd0);
        check("rst_min", 32'(o_min_pwr), 32'hff);
        check("rst_lock", 32'(o_lock_code), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);

        // V-shaped response, with a start pulse mid-sweep that must be ignored
        run_sweep(8'd0, 8'd7, 0, 8'd5, 8'd0, 8 * PT, 1'b1);
        // flat response: tie keeps earliest code
        run_sweep(8'd10, 8'd12, 1, 8'd10, 8'h40, 3 * PT, 1'b0);
        // reversed bounds sweep the single point lo, with junk valids outside WAIT
        junk = 1'b1;
        run_sweep(8'd9, 8'd3, 0, 8'd9, 8'd40, PT, 1'b0);
        junk = 1'b0;
        // read backpressure of six cycles on the first point
        x0 = xfers;
        bp_left = 6;
        run_sweep(8'd0, 8'd2, 0, 8'd2, 8'd30, 3 * PT + 6, 1'b0);
        check("read_xfers", 32'(xfers - x0), 32'd3);

        // reset during WAIT of code 4
        mode = 0;
        n = done_cnt;
        @(negedge i_clk);
        i_code_lo = 8'd0;
        i_code_hi = 8'd7;
        i_start   = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge i_clk);
            #1;
            if (o_pwr_detect_rdy && o_dac_tune == 8'd4) found = 1'b1;
        end
        check("reach_wait4", 32'(found), 32'd1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_dac", 32'(o_dac_tune), 32'd0);
        check("mid_rst_rdval", 32'(o_pwr_read_val), 32'd0);
        check("mid_rst_detrdy", 32'(o_pwr_detect_rdy), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_done", 32'(o_done), 32'd0);
        check("mid_rst_lock", 32'(o_lock_code), 32'd0);
        check("mid_rst_min", 32'(o_min_pwr), 32'hff);
        check("mid_rst_state", 32'(o_state), 32'(ST_IDLE));
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (20) @(posedge i_clk);
        #1;
        check("no_done_after_rst", 32'(done_cnt - n), 32'd0);
        check("idle_after_rst", 32'(o_busy), 32'd0);
        run_sweep(8'd0, 8'd7, 0, 8'd5, 8'd0, 8 * PT, 1'b0);

        // top code: must not wrap
        run_sweep(8'd255, 8'd255, 1, 8'd255, 8'h40, PT, 1'b0);

        repeat (5) @(posedge i_clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
